// File: rtl/pa_ifu_icache_inv.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : pa_ifu_icache_inv                                                 |
// | Brief   : Icache invalidate sequencer (invalidate-all walk or single set).  |
// |           Macro PA_ICACHE_INV_PA_EN enables invalidate-by-physical-address. |
// | Rev     : 1.0                                                               |
// +-----------------------------------------------------------------------------+
module pa_ifu_icache_inv (
    input  logic        forever_cpuclk,
    input  logic        cpurst,
    input  logic        ext_inst_ifu_icc_req,
    input  logic        ext_inst_ifu_icc_type,
    input  logic [31:0] ext_inst_ifu_icc_addr,
    output logic        ext_inst_ifu_inv_done,
    input  logic        ifu_inv_fetch_idle,
    output logic        inv_ifu_busy,
    output logic        inv_tag_req,
    input  logic        inv_tag_grant,
    output logic [7:0]  inv_tag_idx
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_INV  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [7:0] r_cnt;
    logic       w_pa;
    logic [7:0] w_tgt_idx;
    logic       w_unused_ok;

`ifdef PA_ICACHE_INV_PA_EN
    logic       r_type;
    logic [7:0] r_pa_idx;

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            r_type   <= 1'b0;
            r_pa_idx <= 8'h00;
        end else if (r_state == c_IDLE && ext_inst_ifu_icc_req) begin
            r_type   <= ext_inst_ifu_icc_type;
            r_pa_idx <= ext_inst_ifu_icc_addr[12:5];
        end
    end

    assign w_pa        = r_type;
    assign w_tgt_idx   = r_type ? r_pa_idx : r_cnt;
    assign w_unused_ok = ^{ext_inst_ifu_icc_addr[31:13], ext_inst_ifu_icc_addr[4:0]};
`else
    // Without by-PA support every request is a full walk; type/addr are don't-care.
    assign w_pa        = 1'b0;
    assign w_tgt_idx   = r_cnt;
    assign w_unused_ok = ^{ext_inst_ifu_icc_type, ext_inst_ifu_icc_addr};
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: if (ext_inst_ifu_icc_req) w_state_nxt = c_WAIT;
            c_WAIT: if (ifu_inv_fetch_idle)   w_state_nxt = c_INV;
            c_INV: begin
                if (inv_tag_grant && (w_pa || r_cnt == 8'hff)) w_state_nxt = c_DONE;
            end
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counter only advances on a granted write, so withheld grants hold the index.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            r_cnt <= 8'h00;
        end else if (r_state == c_IDLE) begin
            r_cnt <= 8'h00;
        end else if (r_state == c_INV && inv_tag_grant && !w_pa) begin
            r_cnt <= r_cnt + 8'h01;
        end
    end

    assign ext_inst_ifu_inv_done = (r_state == c_DONE);
    assign inv_tag_req           = (r_state == c_INV);
    assign inv_ifu_busy          = (r_state != c_IDLE);
    assign inv_tag_idx           = (r_state == c_INV) ? w_tgt_idx : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_pa_ifu_icache_inv.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : tb_pa_ifu_icache_inv                                              |
// | Brief   : Directed self-checking bench for pa_ifu_icache_inv.               |
// | Rev     : 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_pa_ifu_icache_inv;

    logic        clk;
    logic        rst;
    logic        req;
    logic        typ;
    logic [31:0] addr;
    logic        done;
    logic        fetch_idle;
    logic        busy;
    logic        tag_req;
    logic        grant;
    logic [7:0]  idx;

    int n_checks;
    int n_fail;

    pa_ifu_icache_inv dut (
        .forever_cpuclk        (clk),
        .cpurst                (rst),
        .ext_inst_ifu_icc_req  (req),
        .ext_inst_ifu_icc_type (typ),
        .ext_inst_ifu_icc_addr (addr),
        .ext_inst_ifu_inv_done (done),
        .ifu_inv_fetch_idle    (fetch_idle),
        .inv_ifu_busy          (busy),
        .inv_tag_req           (tag_req),
        .inv_tag_grant         (grant),
        .inv_tag_idx           (idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one request and follows it to done. k counts cycles after the request cycle.
    task automatic run_op(input string name, input logic t, input logic [31:0] a,
                          input int idle_delay, input logic [7:0] gap_at, input int gap_len,
                          input bit pa_mode, input int exp_done);
        int         w;
        int         writes;
        int         gap_left;
        int         exp_writes;
        logic [7:0] exp_idx;
        logic [7:0] pa_idx;
        bit         finished;
        w          = (idle_delay < 1) ? 1 : idle_delay;
        writes     = 0;
        gap_left   = gap_len;
        exp_writes = pa_mode ? 1 : 256;
        exp_idx    = 8'h00;
        pa_idx     = a[12:5];
        finished   = 1'b0;
        @(negedge clk);
        req        = 1'b1;
        typ        = t;
        addr       = a;
        grant      = 1'b1;
        fetch_idle = (idle_delay == 0);
        for (int k = 1; k <= 600 && !finished; k++) begin
            @(negedge clk);
            if (done) begin
                check({name, "_done_cycle"}, k, exp_done);
                check({name, "_done_busy"}, {31'd0, busy}, 32'd1);
                check({name, "_done_noreq"}, {31'd0, tag_req}, 32'd0);
                req = 1'b0;
                @(negedge clk);
                check({name, "_done_onecyc"}, {31'd0, done}, 32'd0);
                check({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
                finished = 1'b1;
            end else if (k <= w) begin
                check({name, "_wait_busy"}, {31'd0, busy}, 32'd1);
                check({name, "_wait_noreq"}, {31'd0, tag_req}, 32'd0);
            end else begin
                check({name, "_inv_req"}, {31'd0, tag_req}, 32'd1);
                check({name, "_inv_idx"}, {24'd0, idx}, {24'd0, pa_mode ? pa_idx : exp_idx});
                if (gap_len > 0 && idx == gap_at && gap_left > 0) begin
                    grant = 1'b0;
                    gap_left--;
                end else begin
                    grant = 1'b1;
                end
                if (tag_req && grant) begin
                    writes++;
                    exp_idx++;
                end
            end
            if (k == idle_delay) fetch_idle = 1'b1;
            // Request inputs change mid-operation; the latched values must govern.
            if (k == 1) begin
                typ  = ~t;
                addr = ~a;
            end
        end
        if (!finished) check({name, "_timeout"}, 32'd0, 32'd1);
        check({name, "_writes"}, writes, exp_writes);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got_done;
        bit reached;
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        req        = 1'b0;
        typ        = 1'b0;
        addr       = 32'h0;
        fetch_idle = 1'b1;
        grant      = 1'b0;
        #2;
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_req", {31'd0, tag_req}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_idx", {24'd0, idx}, 32'd0);
        req = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_hold_busy", {31'd0, busy}, 32'd0);
        req = 1'b0;
        rst = 1'b0;

        run_op("all", 1'b0, 32'h0000_1FE0, 0, 8'h00, 0, 1'b0, 258);
        run_op("gap", 1'b0, 32'h0000_0000, 0, 8'h40, 5, 1'b0, 263);
`ifdef PA_ICACHE_INV_PA_EN
        run_op("pa", 1'b1, 32'h0000_1FE0, 0, 8'h00, 0, 1'b1, 3);
        run_op("fbusy", 1'b1, 32'h0000_0A40, 10, 8'h00, 0, 1'b1, 12);
`else
        run_op("pa_off", 1'b1, 32'h0000_1FE0, 0, 8'h00, 0, 1'b0, 258);
        run_op("fbusy", 1'b1, 32'h0000_0A40, 10, 8'h00, 0, 1'b0, 267);
`endif

        // Abort a walk at index 0x80 with reset.
        @(negedge clk);
        req        = 1'b1;
        typ        = 1'b0;
        addr       = 32'h0;
        grant      = 1'b1;
        fetch_idle = 1'b1;
        reached    = 1'b0;
        got_done   = 1'b0;
        for (int k = 0; k < 400 && !reached; k++) begin
            @(negedge clk);
            if (done) got_done = 1'b1;
            if (tag_req && idx == 8'h80) reached = 1'b1;
        end
        check("abort_reached", {31'd0, reached}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_req", {31'd0, tag_req}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_idx", {24'd0, idx}, 32'd0);
        req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) got_done = 1'b1;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) got_done = 1'b1;
        end
        check("abort_no_done", {31'd0, got_done}, 32'd0);
`ifdef PA_ICACHE_INV_PA_EN
        run_op("post_rst", 1'b1, 32'h0000_0020, 0, 8'h00, 0, 1'b1, 3);
`else
        run_op("post_rst", 1'b1, 32'h0000_0020, 0, 8'h00, 0, 1'b0, 258);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pa_ifu_icache_inv.md
PA_IFU_ICACHE_INV -- requirements
Module: pa_ifu_icache_inv

Interface
REQ-001 SHALL have port forever_cpuclk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port cpurst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port ext_inst_ifu_icc_req, input, 1 bit: icache operation request from the cache-instruction unit; held until done is seen.
REQ-004 SHALL have port ext_inst_ifu_icc_type, input, 1 bit: 0 = invalidate all, 1 = invalidate by physical address.
REQ-005 SHALL have port ext_inst_ifu_icc_addr, input, 32 bits: physical address for by-PA operations.
REQ-006 SHALL have port ext_inst_ifu_inv_done, output, 1 bit: one-cycle completion pulse.
REQ-007 SHALL have port ifu_inv_fetch_idle, input, 1 bit: 1 = no icache refill or fetch access in flight.
REQ-008 SHALL have port inv_ifu_busy, output, 1 bit: 1 = fetch must not start new icache accesses.
REQ-009 SHALL have port inv_tag_req, output, 1 bit: tag-array invalidate-write request.
REQ-010 SHALL have port inv_tag_grant, input, 1 bit: tag-array port granted this cycle; the write completes in the same cycle.
REQ-011 SHALL have port inv_tag_idx, output, 8 bits: set index written; every way of that set is cleared.

Function
REQ-012 SHALL implement a state machine with states IDLE, WAIT, INV and DONE.
REQ-013 IDLE: on ext_inst_ifu_icc_req=1, SHALL latch type and ext_inst_ifu_icc_addr[12:5] and go to WAIT.
REQ-014 WAIT: inv_ifu_busy=1; SHALL go to INV in the cycle after ifu_inv_fetch_idle=1 is sampled.
REQ-015 INV, invalidate-all: index counter starts at 0; inv_tag_req=1; inv_tag_idx = counter.
REQ-016 INV, invalidate-all: counter SHALL increment only on inv_tag_grant; on a grant at index 255 (8-bit wrap) it SHALL go to DONE.
REQ-017 INV, by-PA: inv_tag_idx = latched addr[12:5]; on the first grant it SHALL go to DONE.
REQ-018 DONE SHALL last exactly one cycle with ext_inst_ifu_inv_done=1 and inv_ifu_busy=1, then return to IDLE.
REQ-019 Upstream deasserts the request in the cycle after done; a request seen in IDLE is always a new operation.
REQ-020 inv_tag_req SHALL be 1 only in INV; inv_ifu_busy SHALL be 1 in WAIT, INV and DONE.
REQ-021 Grant withheld: the request and index SHALL hold unchanged, with no timeout.
REQ-022 Minimum latency from request to done: by-PA 3 cycles; invalidate-all 258 cycles with continuous grant and fetch idle.
REQ-023 Request input changes outside IDLE SHALL be ignored; the latched values govern the operation.

Reset
REQ-024 While cpurst=1: state IDLE, counter 0, latched index 0, latched type 0.
REQ-025 While cpurst=1: ext_inst_ifu_inv_done=0, inv_tag_req=0, inv_ifu_busy=0, inv_tag_idx=0.
REQ-026 Reset mid-operation SHALL abort immediately with no done pulse; the cache-instruction unit is reset together with this block.

Configuration
REQ-027 Macro PA_ICACHE_INV_PA_EN defined: by-PA behaves as REQ-017.
REQ-028 Macro PA_ICACHE_INV_PA_EN undefined: type is ignored, every request performs invalidate-all, and the addr[12:5] latch is not built.

Verification
REQ-029 Invalidate-all: type=0, fetch_idle=1, grant=1 constant -> indices 0..255 on consecutive cycles; done pulses 258 cycles after the request edge.
REQ-030 By-PA: addr=0x0000_1FE0, fetch idle -> exactly one write with idx=0xFF; done 3 cycles after the request.
REQ-031 Fetch busy: fetch_idle=0 for 10 cycles after the request -> busy=1 and no inv_tag_req; INV is entered the cycle after fetch_idle rises.
REQ-032 Grant gaps: grant deasserted at idx=0x40 for 5 cycles -> idx holds at 0x40 and no index is skipped; done is delayed by 5 cycles.
REQ-033 Reset at idx=0x80 -> all outputs 0 at once; no done; a new by-PA request afterwards completes normally.
REQ-034 Macro undefined: a type=1 request -> a full 256-set walk.
